// File: rtl/lzw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lzw_pkg
// Description : Widths and packer state encoding shared by the LZW blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package lzw_pkg;

  localparam int LZW_CODE_W = 12;
  localparam int LZW_BYTE_W = 8;

  typedef enum logic [1:0] {
    PACK_IDLE  = 2'd0,
    PACK_ACCUM = 2'd1,
    PACK_FLUSH = 2'd2,
    PACK_DONE  = 2'd3
  } pack_state_e;

endpackage
`default_nettype wire

// File: rtl/lzw_bit_accum.sv
`default_nettype none
// ============================================================================
// Module      : lzw_bit_accum
// Description : Right-aligned bit accumulator; appends whole codes and
//               presents the oldest OUT_W bits, zero-padded when short.
// Revision    : 1.0 - initial release
// ============================================================================
module lzw_bit_accum
  import lzw_pkg::*;
#(
  parameter int CODE_W = LZW_CODE_W,
  parameter int OUT_W  = LZW_BYTE_W,
  parameter int ACC_W  = CODE_W + OUT_W - 1,
  parameter int CNT_W  = $clog2(ACC_W + 1)
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              i_append,
  input  logic [CODE_W-1:0] i_code,
  input  logic              i_take_byte,
  input  logic              i_take_pad,
  input  logic              i_clear,
  output logic              o_has_byte,
  output logic              o_empty,
  output logic [OUT_W-1:0]  o_byte
);

  localparam logic [CNT_W-1:0] c_code_w = CNT_W'(CODE_W);
  localparam logic [CNT_W-1:0] c_out_w  = CNT_W'(OUT_W);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [OUT_W-1:0] w_byte;

  always_ff @(posedge Clk) begin
    if (!Reset_n || i_clear) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_append) begin
      r_acc <= {r_acc[ACC_W-CODE_W-1:0], i_code};
      r_cnt <= r_cnt + c_code_w;
    end else if (i_take_byte) begin
      r_cnt <= r_cnt - c_out_w;
    end else if (i_take_pad) begin
      r_cnt <= '0;
    end
  end

  // Walking down from the oldest bit covers both the full byte and the
  // left-aligned, zero-padded remainder with one structure.
  always_comb begin
    w_byte = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (CNT_W'(i) < r_cnt) begin
        w_byte[OUT_W-1-i] = r_acc[r_cnt - CNT_W'(i + 1)];
      end
    end
  end

  assign o_byte     = w_byte;
  assign o_has_byte = (r_cnt >= c_out_w);
  assign o_empty    = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/lzw_code_packer.sv
`default_nettype none
// ============================================================================
// Module      : lzw_code_packer
// Description : Packs CODE_W-bit LZW codes MSB-first into an OUT_W byte
//               stream with zero-padded end-of-stream flush.
//               Optional macro PACKER_BYTE_COUNT_EN adds oByteCount.
// Revision    : 1.0 - initial release
// ============================================================================
module lzw_code_packer
  import lzw_pkg::*;
#(
  parameter int CODE_W = LZW_CODE_W,
  parameter int OUT_W  = LZW_BYTE_W
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [CODE_W-1:0] iCode,
  input  logic              iCodeValid,
  output logic              oCodeReady,
  input  logic              iFlush,
  output logic [OUT_W-1:0]  oByte,
  output logic              oByteValid,
  input  logic              iByteReady,
  output logic              oFlushDone,
  output logic              oBusy
`ifdef PACKER_BYTE_COUNT_EN
  ,
  output logic [23:0]       oByteCount
`endif
);

  localparam int ACC_W = CODE_W + OUT_W - 1;
  localparam int CNT_W = $clog2(ACC_W + 1);

  pack_state_e r_state;
  pack_state_e w_state_nxt;
  logic        r_flush_pend;
  logic        w_flush_pend_nxt;

  logic        w_has_byte;
  logic        w_empty;
  logic        w_code_ready;
  logic        w_byte_valid;
  logic        w_accept;
  logic        w_xfer;

  assign w_accept = iCodeValid && w_code_ready;
  assign w_xfer   = w_byte_valid && iByteReady;

  lzw_bit_accum #(
    .CODE_W (CODE_W),
    .OUT_W  (OUT_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) u_accum (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .i_append    (w_accept),
    .i_code      (iCode),
    .i_take_byte (w_xfer && w_has_byte),
    .i_take_pad  (w_xfer && !w_has_byte),
    .i_clear     (r_state == PACK_DONE),
    .o_has_byte  (w_has_byte),
    .o_empty     (w_empty),
    .o_byte      (oByte)
  );

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      r_state      <= PACK_IDLE;
      r_flush_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_pend <= w_flush_pend_nxt;
    end
  end

  // A flush arriving with an accepted code waits for that code to drain.
  always_comb begin
    w_state_nxt      = r_state;
    w_flush_pend_nxt = r_flush_pend;
    unique case (r_state)
      PACK_IDLE, PACK_ACCUM: begin
        if (iFlush) begin
          w_flush_pend_nxt = 1'b1;
        end
        if (w_accept) begin
          w_state_nxt = PACK_ACCUM;
        end else if ((r_flush_pend || iFlush) && !w_has_byte) begin
          w_state_nxt = PACK_FLUSH;
        end
      end
      PACK_FLUSH: begin
        if (w_empty || w_xfer) begin
          w_state_nxt = PACK_DONE;
        end
      end
      PACK_DONE: begin
        w_state_nxt      = PACK_IDLE;
        w_flush_pend_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = PACK_IDLE;
      end
    endcase
  end

  always_comb begin
    w_code_ready = ((r_state == PACK_IDLE) || (r_state == PACK_ACCUM)) &&
                   !w_has_byte && !r_flush_pend;
    w_byte_valid = w_has_byte || ((r_state == PACK_FLUSH) && !w_empty);
    oFlushDone   = (r_state == PACK_DONE);
    oBusy        = (r_state != PACK_IDLE) || !w_empty;
  end

  assign oCodeReady = w_code_ready;
  assign oByteValid = w_byte_valid;

`ifdef PACKER_BYTE_COUNT_EN
  logic [23:0] r_byte_count;

  always_ff @(posedge Clk) begin
    if (!Reset_n || (r_state == PACK_DONE)) begin
      r_byte_count <= '0;
    end else if (w_xfer && (r_byte_count != 24'hFFFFFF)) begin
      r_byte_count <= r_byte_count + 24'd1;
    end
  end

  assign oByteCount = r_byte_count;
`endif

endmodule
`default_nettype wire

// File: doc/lzw_code_packer.md
Name: lzw_code_packer

Overview:
- Downstream of the LZW register/datapath block. Consumes the 12-bit dictionary codes it presents on its code output and packs them MSB-first into a contiguous byte stream for the output buffer/UART stage.
- Two codes become three bytes. An end-of-stream flush emits the final partial byte, zero-padded.

Parameters:
- CODE_W, 12, width of an incoming code; legal range 9..16.
- OUT_W, 8, width of an output byte; must be less than CODE_W.
- ACC_W, CODE_W+OUT_W-1, accumulator width (derived; do not override).

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Reset_n  in  1  synchronous, active-low reset.
- iCode  in  CODE_W  code from the LZW datapath.
- iCodeValid  in  1  iCode is valid this cycle.
- oCodeReady  out  1  packer accepts iCode this cycle.
- iFlush  in  1  end-of-stream request; one-cycle pulse.
- oByte  out  OUT_W  packed output byte.
- oByteValid  out  1  oByte is valid.
- iByteReady  in  1  downstream accepts oByte.
- oFlushDone  out  1  one-cycle pulse when the flush completes.
- oBusy  out  1  high whenever the state is not IDLE or the accumulator count is nonzero.

Behaviour:
- Reset (Reset_n=0 at a Clk edge), taking priority over everything: acc=0, cnt=0, state=IDLE, flush_pend=0. Resulting outputs: oByte=0, oByteValid=0, oCodeReady=1, oFlushDone=0, oBusy=0. A reset during any operation discards buffered bits with no output.
- State: acc[ACC_W-1:0] holds cnt valid bits, right-aligned; the oldest bit is at acc[cnt-1]. cnt ranges 0..ACC_W.
- States: IDLE, ACCUM, FLUSH, DONE.
- oCodeReady = (state==IDLE or ACCUM) and cnt<OUT_W and not flush_pend. Accept = iCodeValid and oCodeReady.
- On accept: acc <= (acc<<CODE_W) | iCode; cnt <= cnt+CODE_W; state <= ACCUM.
- Emit path: oByteValid = (cnt>=OUT_W) or (state==FLUSH and cnt>0). oByte = acc[cnt-1 -: OUT_W] when cnt>=OUT_W; otherwise the remaining bits left-aligned with zero LSB padding.
- Transfer = oByteValid and iByteReady; on transfer cnt <= cnt-OUT_W, or 0 for the padded byte. Accept and emit are mutually exclusive (cnt<OUT_W versus cnt>=OUT_W), so the accumulator never overflows.
- While oByteValid=1 and iByteReady=0, oByte and oByteValid hold stable. No combinational path from iByteReady to oByteValid.
- Steady throughput: 3 bytes per 2 codes. cnt sequence is 0→12→4→16→8→0; 5 cycles per 2 codes with iByteReady=1.
- Latency: first byte valid the cycle after the accepting edge.
- iFlush when the state is IDLE or ACCUM: set flush_pend. While flush_pend=1 and cnt>=OUT_W, keep draining. Once cnt<OUT_W, go to FLUSH.
- iFlush coinciding with an accepted code: the code is packed first, then the flush.
- FLUSH: emit the padded byte if cnt>0, then DONE. DONE: oFlushDone=1 for one cycle, then IDLE with cnt=0 and flush_pend=0.
- Flush with an empty accumulator: FLUSH→DONE with no bytes; oFlushDone 2 cycles after iFlush.
- iFlush in FLUSH or DONE is ignored. iCode bits above CODE_W do not exist; the caller zero-extends narrower codes.

Optional Feature:
- Macro PACKER_BYTE_COUNT_EN.
- Defined: adds output oByteCount [23:0], a count of transferred bytes including the pad byte. It clears on reset and on the DONE→IDLE transition; the value is valid during oFlushDone. It saturates at 24'hFFFFFF.
- Undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package lzw_pkg:
  - localparams LZW_CODE_W=12 and LZW_BYTE_W=8.
  - state enum PACK_IDLE/PACK_ACCUM/PACK_FLUSH/PACK_DONE.
  - Used by the datapath, the packer and a future unpacker.
- One sub-module, lzw_bit_accum: acc/cnt storage with append/extract ports. The FSM and handshake remain in the top level.

Test Plan:
- Codes 0xABC then 0x123, iByteReady=1 → bytes 0xAB, 0xC1, 0x23 in consecutive valid cycles; cnt returns to 0.
- Code 0x041 then iFlush → bytes 0x04, 0x10 (pad 0000); oFlushDone pulses the cycle after 0x10 transfers.
- Codes 0xFFF,0x000 with iByteReady low for 5 cycles after the first byte → oByte=0xFF held stable; oCodeReady=0 throughout; resumes with 0xF0, 0x00.
- iFlush with empty accumulator → no oByteValid; oFlushDone=1 exactly 2 cycles later; oBusy=0 afterwards.
- Reset_n=0 for one cycle while cnt=4 after 0xABC → next code 0x123 yields 0x12 and 0x30 only after flush; no stale 0xC nibble.
- With PACKER_BYTE_COUNT_EN: 3 codes plus flush → 5 bytes; oByteCount=5 at oFlushDone, then 0.
